// File: rtl/prime_sieve_scroller_pkg.sv
// Shared definitions for the prime sieve scroller.
//   state_t   : FSM encoding, also driven onto the state LEDs
//   clog2     : elaboration-time ceiling log2
//   ASCII_*   : character offsets for the downstream LCD formatter
package prime_sieve_scroller_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SIEVE   = 2'd1,
    S_COLLECT = 2'd2,
    S_SCROLL  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;  // '0'
  localparam logic [7:0] ASCII_HEXA  = 8'h37;  // 'A' - 10
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prime_table.sv
// Prime table: single-port RAM, DEPTH x DW, synchronous write, registered read.
//   clk   : clock
//   we    : write enable (wdata -> mem[addr])
//   addr  : shared read/write address
//   wdata : write data
//   rdata : mem[addr] as of the previous edge
module prime_table #(
  parameter int DEPTH = 257,
  parameter int AW    = 9,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/prime_sieve_scroller.sv
// Prime sieve scroller: Eratosthenes sieve over [2, MAX_N), primes compacted
// into a 1-based table, then two consecutive entries shown as a timed scroll.
//   clk, reset           : clock, async active-high reset
//   start                : pulse, (re)run the sieve from any state
//   dir_toggle           : pulse, flip scroll direction
//   pause_toggle         : pulse, flip pause
//   busy / done          : in SIEVE or COLLECT / in SCROLL
//   overflow             : more primes found than PRIME_DEPTH
//   dir, paused, state   : status for LEDs
//   prime_count          : primes stored
//   idx_a/val_a, idx_b/val_b : the two display rows (index, prime)
module prime_sieve_scroller
  import prime_sieve_scroller_pkg::*;
#(
  parameter int MAX_N       = 1024,
  parameter int VAL_W       = 10,
  parameter int PRIME_DEPTH = 256,
  parameter int IDX_W       = 8,
  parameter int TICK_DIV    = 70_000_000,
  parameter int AUTO_START  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir_toggle,
  input  logic             pause_toggle,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             dir,
  output logic             paused,
  output logic [1:0]       state,
  output logic [IDX_W-1:0] prime_count,
  output logic [IDX_W-1:0] idx_a,
  output logic [VAL_W-1:0] val_a,
  output logic [IDX_W-1:0] idx_b,
  output logic [VAL_W-1:0] val_b
);
  // count must hold PRIME_DEPTH itself, so it is sized independently of IDX_W
  localparam int CW  = clog2(PRIME_DEPTH + 1);
  localparam int TW  = clog2(TICK_DIV);
  localparam int SQW = 2 * VAL_W;
  localparam int JW  = VAL_W + 1;   // j may overshoot MAX_N by up to i
  localparam logic [CW-1:0]    ONE   = CW'(1);
  localparam logic [CW-1:0]    DEPTH = CW'(PRIME_DEPTH);
  localparam logic [TW-1:0]    TMAX  = TW'(TICK_DIV - 1);
  localparam logic [VAL_W-1:0] KLAST = VAL_W'(MAX_N - 1);
  localparam logic [SQW-1:0]   NSQ   = SQW'(MAX_N);
  localparam logic [JW-1:0]    NJ    = JW'(MAX_N);

  state_t                st, st_d;
  logic [MAX_N-1:0]      bitmap;
  logic [VAL_W-1:0]      i, k;
  logic [JW-1:0]         j;
  logic [SQW-1:0]        isq;
  logic                  inner, boot, q_vld;
  logic                  go, tick, we, hit;
  logic [CW-1:0]         count, idx, step, idx_nx, idx_b_nx;
  logic [IDX_W-1:0]      q_idx_a, q_idx_b;
  logic [TW-1:0]         cnt;
  logic [1:0][CW-1:0]    addr;
  logic [1:0][VAL_W-1:0] rdata;

  assign go       = start | ((AUTO_START != 0) & boot & (st == S_IDLE));
  assign isq      = SQW'(i) * SQW'(i);
  assign hit      = bitmap[k];
  assign we       = (st == S_COLLECT) & hit & (count != DEPTH) & ~go;
  // a pause_toggle in the tick cycle swallows the tick when pausing;
  // when resuming, paused is still 1 here so no tick either
  assign tick     = (st == S_SCROLL) & ~paused & ~pause_toggle & (cnt == TMAX) & ~go;
  assign step     = dir ? ((idx == ONE) ? count : idx - ONE)
                        : ((idx == count) ? ONE : idx + ONE);
  assign idx_nx   = tick ? step : idx;
  assign idx_b_nx = (idx_nx == count) ? ONE : idx_nx + ONE;

  // Both table copies hold identical contents; row A and row B each read
  // their own copy so the pair is fetched in the same cycle.
  assign addr[0] = (st == S_COLLECT) ? count + ONE : idx_nx;
  assign addr[1] = (st == S_COLLECT) ? count + ONE : idx_b_nx;

  for (genvar p = 0; p < 2; p++) begin : g_tab
    prime_table #(.DEPTH(PRIME_DEPTH + 1), .AW(CW), .DW(VAL_W)) u_tab (
      .clk   (clk),
      .we    (we),
      .addr  (addr[p]),
      .wdata (k),
      .rdata (rdata[p])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_IDLE;
    else       st <= st_d;
  end

  always_comb begin
    st_d = st;
    case (st)
      S_SIEVE:   if (!inner && isq >= NSQ) st_d = S_COLLECT;
      S_COLLECT: if (k == KLAST) st_d = S_SCROLL;
      default:   ;
    endcase
    if (go) st_d = S_SIEVE;
  end

  // bitmap contents are don't-care after reset, so no reset term
  always_ff @(posedge clk) begin
    if (go) bitmap <= '1;
    else if (st == S_SIEVE && inner && j < NJ) bitmap[j[VAL_W-1:0]] <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boot     <= 1'b1;
      dir      <= 1'b0;
      paused   <= 1'b0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      inner    <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
    end else begin
      boot   <= 1'b0;
      dir    <= dir ^ dir_toggle;
      paused <= paused ^ pause_toggle;
      cnt    <= (st != S_SCROLL || go || paused || pause_toggle || cnt == TMAX) ? '0 : cnt + 1'b1;
      if (go) begin
        i        <= VAL_W'(2);
        k        <= VAL_W'(2);
        inner    <= 1'b0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        case (st)
          S_SIEVE: begin
            if (inner) begin
              if (j >= NJ) begin
                inner <= 1'b0;
                i     <= i + 1'b1;
              end else begin
                j <= j + JW'(i);
              end
            end else if (isq < NSQ) begin
              if (bitmap[i]) begin
                j     <= JW'(isq);
                inner <= 1'b1;
              end else begin
                i <= i + 1'b1;
              end
            end
          end
          S_COLLECT: begin
            k <= k + 1'b1;
            if (we) count <= count + ONE;
            else if (hit && count == DEPTH) overflow <= 1'b1;
            if (k == KLAST) idx <= ONE;
          end
          S_SCROLL: idx <= idx_nx;
          default:  ;
        endcase
      end
    end
  end

  // q_idx_* track the address whose data lands in rdata, so the output
  // register always loads a matched (index, value) pair for both rows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_vld   <= 1'b0;
      q_idx_a <= '0;
      q_idx_b <= '0;
      idx_a   <= '0;
      val_a   <= '0;
      idx_b   <= '0;
      val_b   <= '0;
    end else begin
      q_vld   <= (st == S_SCROLL) & ~go;
      q_idx_a <= IDX_W'(idx_nx);
      q_idx_b <= IDX_W'(idx_b_nx);
      if (q_vld && st == S_SCROLL && !go) begin
        idx_a <= q_idx_a;
        val_a <= rdata[0];
        idx_b <= q_idx_b;
        val_b <= rdata[1];
      end else begin
        idx_a <= '0;
        val_a <= '0;
        idx_b <= '0;
        val_b <= '0;
      end
    end
  end

  assign busy        = (st == S_SIEVE) | (st == S_COLLECT);
  assign done        = (st == S_SCROLL);
  assign state       = st;
  assign prime_count = IDX_W'(count);
endmodule

// File: tb/tb_prime_sieve_scroller.sv
module tb_prime_sieve_scroller;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst1 = 1'b1, rst2 = 1'b1;
  logic start1 = 1'b0, dtog1 = 1'b0, ptog1 = 1'b0;
  logic start2 = 1'b0, dtog2 = 1'b0, ptog2 = 1'b0;

  logic       busy1, done1, ovf1, dir1, paused1;
  logic [1:0] st1;
  logic [7:0] pc1, ia1, ib1;
  logic [9:0] va1, vb1;
  logic       busy2, done2, ovf2, dir2, paused2;
  logic [1:0] st2;
  logic [4:0] pc2, ia2, ib2;
  logic [6:0] va2, vb2;

  always #5 clk = ~clk;

  prime_sieve_scroller #(.MAX_N(1024), .VAL_W(10), .PRIME_DEPTH(256), .IDX_W(8),
                         .TICK_DIV(TD), .AUTO_START(1)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .dir_toggle(dtog1), .pause_toggle(ptog1),
    .busy(busy1), .done(done1), .overflow(ovf1), .dir(dir1), .paused(paused1), .state(st1),
    .prime_count(pc1), .idx_a(ia1), .val_a(va1), .idx_b(ib1), .val_b(vb1));

  prime_sieve_scroller #(.MAX_N(100), .VAL_W(7), .PRIME_DEPTH(16), .IDX_W(5),
                         .TICK_DIV(TD), .AUTO_START(1)) dut2 (
    .clk(clk), .reset(rst2), .start(start2), .dir_toggle(dtog2), .pause_toggle(ptog2),
    .busy(busy2), .done(done2), .overflow(ovf2), .dir(dir2), .paused(paused2), .state(st2),
    .prime_count(pc2), .idx_a(ia2), .val_a(va2), .idx_b(ib2), .val_b(vb2));

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // reference primes below 1024 by trial division
  int ref_p [0:256];
  int ref_cnt;

  function automatic logic [35:0] ev(input int a);
    int b;
    b = (a == ref_cnt) ? 1 : a + 1;
    return {8'(a), 10'(ref_p[a]), 8'(b), 10'(ref_p[b])};
  endfunction

  // scoreboard: display pair expected from a given cycle onward
  typedef struct { int due; logic [35:0] v; } exp_t;
  exp_t q[$];

  int          cyc = 0, m_a = 0, m_cnt = 0;
  logic [35:0] cur = '0;
  logic        m_dir = 1'b0, m_paused = 1'b0, prev_done = 1'b0;
  bit          tk;

  always @(negedge clk) begin
    cyc++;
    if (rst1) begin
      q.delete();
      cur = '0; m_dir = 1'b0; m_paused = 1'b0; prev_done = 1'b0; m_cnt = 0;
    end else begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        cur = q[0].v;
        void'(q.pop_front());
      end
      chk("rows", {dir1, paused1, ia1, va1, ib1, vb1}, {m_dir, m_paused, cur});
      if (start1) begin
        q.delete();
        q.push_back('{cyc + 1, 36'd0});
        m_cnt = 0;
      end else if (done1) begin
        if (!prev_done) begin
          m_a = 1; m_cnt = 0;
          q.push_back('{cyc + 2, ev(1)});
        end
        tk = !m_paused && !ptog1 && m_cnt == TD - 1;
        if (m_paused || ptog1 || m_cnt == TD - 1) m_cnt = 0; else m_cnt++;
        if (tk) begin
          if (!m_dir) m_a = (m_a == ref_cnt) ? 1 : m_a + 1;
          else        m_a = (m_a == 1) ? ref_cnt : m_a - 1;
          q.push_back('{cyc + 2, ev(m_a)});
        end
      end else begin
        m_cnt = 0;
      end
      prev_done = done1;
      m_dir     = m_dir ^ dtog1;
      m_paused  = m_paused ^ ptog1;
    end
  end

  task automatic wait_done(input string tag);
    for (int n = 0; n < 4000 && !done1; n++) @(negedge clk);
    chk(tag, done1, 1);
  endtask

  task automatic wait_ia(input string tag, input logic [7:0] v, input int bud);
    for (int n = 0; n < bud && ia1 != v; n++) @(negedge clk);
    chk(tag, ia1, v);
  endtask

  task automatic wait_step(input string tag);
    logic [7:0] o;
    o = ia1;
    for (int n = 0; n < 20 && ia1 == o; n++) @(negedge clk);
    chk(tag, ia1 != o, 1);
  endtask

  task automatic pulse(input int which);
    @(posedge clk); #1;
    if (which == 0) start1 = 1'b1; else if (which == 1) dtog1 = 1'b1; else ptog1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; dtog1 = 1'b0; ptog1 = 1'b0;
  endtask

  initial begin
    ref_cnt = 0;
    ref_p[0] = 0;
    for (int n = 2; n < 1024; n++) begin
      bit pr;
      pr = 1;
      for (int d = 2; d * d <= n; d++) if (n % d == 0) pr = 0;
      if (pr) begin ref_cnt++; ref_p[ref_cnt] = n; end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", st1, 0);
    chk("rst_outs", {busy1, done1, ovf1, dir1, paused1, pc1, ia1, va1, ib1, vb1}, 0);
    rst1 = 1'b0; rst2 = 1'b0;

    // 1: default sieve
    wait_done("done_first");
    chk("count", pc1, 172);
    chk("ovf", ovf1, 0);
    repeat (3) @(negedge clk);
    chk("first_rows", {ia1, va1, ib1, vb1}, {8'd1, 10'd2, 8'd2, 10'd3});

    // 5: small sieve overflows the 16-entry table
    for (int n = 0; n < 2000 && !done2; n++) @(negedge clk);
    chk("d2_done", done2, 1);
    chk("d2_ovf", ovf2, 1);
    chk("d2_count", pc2, 16);
    for (int n = 0; n < 200 && ia2 != 5'd16; n++) @(negedge clk);
    chk("d2_idx16", ia2, 16);
    chk("d2_val16", va2, 53);
    chk("d2_row_b", {ib2, vb2}, {5'd1, 7'd2});
    for (int n = 0; n < 20 && ia2 == 5'd16; n++) @(negedge clk);
    chk("d2_wrap", {ia2, va2}, {5'd1, 7'd2});

    // 2: forward wrap at the top entry
    wait_ia("reach_172", 8'd172, 1000);
    chk("top_rows", {va1, ib1, vb1}, {10'd1021, 8'd1, 10'd2});
    wait_step("wrap_step");
    chk("wrap_rows", {ia1, va1}, {8'd1, 10'd2});

    // 3: reverse from entry 1, then toggle coincident with a tick
    pulse(1);
    wait_step("rev_step");
    chk("rev_rows", {ia1, va1, ib1, vb1}, {8'd172, 10'd1021, 8'd1, 10'd2});
    pulse(1);
    wait_ia("reach_5", 8'd5, 60);
    repeat (2) @(posedge clk);
    #1 dtog1 = 1'b1;
    @(posedge clk);
    #1 dtog1 = 1'b0;
    wait_step("coinc_step");
    chk("coinc_old_dir", ia1, 6);
    wait_step("coinc_next");
    chk("coinc_new_dir", ia1, 5);

    // 4: pause at entry 10, resume
    pulse(1);
    wait_ia("reach_10", 8'd10, 60);
    pulse(2);
    begin
      int moved;
      moved = 0;
      repeat (40) begin
        @(negedge clk);
        if (ia1 != 8'd10) moved++;
      end
      chk("pause_hold", moved, 0);
    end
    chk("paused_flag", paused1, 1);
    pulse(2);
    repeat (5) @(negedge clk);
    chk("resume_early", ia1, 10);
    @(negedge clk);
    chk("resume_step", ia1, 11);

    // 6: restart mid-scroll
    pulse(0);
    chk("restart_flags", {busy1, done1, st1}, {1'b1, 1'b0, 2'd1});
    chk("restart_rows", {ia1, va1, ib1, vb1}, 0);
    wait_done("done_rerun");
    chk("rerun_count", pc1, 172);
    chk("rerun_ovf", ovf1, 0);
    repeat (3) @(negedge clk);
    chk("rerun_rows", {ia1, va1, ib1, vb1}, {8'd1, 10'd2, 8'd2, 10'd3});

    // 6: async reset mid-sieve
    pulse(0);
    pulse(1);
    repeat (100) @(posedge clk);
    #3;
    chk("mid_sieve", {busy1, done1, st1, dir1}, {1'b1, 1'b0, 2'd1, 1'b1});
    #1 rst1 = 1'b1;
    #1;
    chk("async_rst_state", st1, 0);
    chk("async_rst_outs", {busy1, done1, ovf1, dir1, paused1, pc1, ia1, va1, ib1, vb1}, 0);
    #20 rst1 = 1'b0;
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
